// File: rtl/bcd_seq_adder.sv
// Multi-digit BCD adder controller. One single-digit BCD add per clock,
// least significant digit first, over DIGITS packed BCD digits.
//
// Handshake: start is sampled only while idle. The cycle after an accepted
// start, busy is high for DIGITS cycles. It is followed by a single-cycle
// done pulse with busy low. sum/carry/error are valid while done is high,
// and they hold until the next start is accepted.
module bcd_seq_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  carry,
  output logic                  error,
  output logic [1:0]            dbg_state
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int W  = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cin_q, cin_d;
  logic            carry_q, carry_d;
  logic            error_q, error_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Single-digit datapath signals
  logic [3:0]      x, y, dig;
  logic [4:0]      t;
  logic            invalid, nc;

  // Select the current digit pair and form the corrected BCD digit
  always_comb begin
    x = 4'd0;
    y = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        x = a_q[4*i +: 4];
        y = b_q[4*i +: 4];
      end
    end
    invalid = (x > 4'd9) || (y > 4'd9);
    t       = {1'b0, x} + {1'b0, y} + {4'd0, cin_q};
    dig     = 4'd0;
    nc      = 1'b0;
    if (!invalid) begin
      if (t > 5'd9) begin
        dig = t[3:0] + 4'd6;
        nc  = 1'b1;
      end else begin
        dig = t[3:0];
      end
    end
  end

  // Next-state and next-output logic for the IDLE/ADD/DONE sequencer
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    error_d = error_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sum_d   = '0;
          carry_d = 1'b0;
          error_d = 1'b0;
          idx_d   = '0;
          cin_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IW'(i)) sum_d[4*i +: 4] = dig;
        end
        cin_d = nc;
        if (invalid) error_d = 1'b1;
        if (idx_q == IW'(DIGITS - 1)) begin
          carry_d = nc;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d  = idx_q + IW'(1);
          busy_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      error_q <= error_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign error     = error_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Bench for bcd_seq_adder: directed vectors plus randomized operands,
// compared against a decimal reference model.
module tb_bcd_seq_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a, b;
  logic          busy, done, carry, error;
  logic [W-1:0]  sum;
  logic [1:0]    dbg_state;

  int checks;
  int errors;

  bcd_seq_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry     (carry),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal reference: returns {error, carry, sum}
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] av, input logic [W-1:0] bv);
    int            c;
    int            x, y, t;
    logic          e;
    logic [W-1:0]  s;
    logic [3:0]    d;
    c = 0;
    e = 1'b0;
    s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      x = int'(av[4*i +: 4]);
      y = int'(bv[4*i +: 4]);
      if (x > 9 || y > 9) begin
        e = 1'b1;
        c = 0;
        d = 4'd0;
      end else begin
        t = x + y + c;
        if (t > 9) begin
          t = t - 10;
          c = 1;
        end else begin
          c = 0;
        end
        d = 4'(t);
      end
      s[4*i +: 4] = d;
    end
    return {e, (c == 1), s};
  endfunction

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) begin
      if (allow_bad && $urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else                                        v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  // Drives one add from an IDLE cycle (called just after a negedge).
  // keep=1 holds start high with changing operands throughout the add.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit keep);
    logic [W+1:0] exp;
    exp   = ref_add(av, bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    if (keep) begin a = rand_bcd(1'b1); b = rand_bcd(1'b1); end
    else start = 1'b0;
    check("busy_first", busy, 1);
    check("done_first", done, 0);
    check("sum_cleared", sum, 0);
    check("err_cleared", error, 0);
    check("carry_cleared", carry, 0);
    for (int i = 2; i <= DIGITS; i++) begin
      @(negedge clk);
      if (keep) begin a = rand_bcd(1'b1); b = rand_bcd(1'b1); end
      check("busy_add", busy, 1);
      check("done_add", done, 0);
    end
    @(negedge clk);
    if (keep) begin a = rand_bcd(1'b1); b = rand_bcd(1'b1); end
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("sum", sum, 32'(exp[W-1:0]));
    check("carry", carry, 32'(exp[W]));
    check("error", error, 32'(exp[W+1]));
    @(negedge clk);
    check("done_idle", done, 0);
    check("busy_idle", busy, 0);
    check("sum_hold", sum, 32'(exp[W-1:0]));
    check("carry_hold", carry, 32'(exp[W]));
    check("error_hold", error, 32'(exp[W+1]));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_carry", carry, 0);
    check("rst_error", error, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_start", busy, 0);

    // Directed vectors
    run_op(16'h1234, 16'h5678, 1'b0);
    run_op(16'h9999, 16'h0001, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    check("held_extra_idle", sum, 0);
    run_op(16'h0999, 16'h0001, 1'b0);
    run_op(16'h00A0, 16'h0001, 1'b0);
    run_op(16'h0001, 16'h0001, 1'b0);

    // Start held high: back-to-back adds every DIGITS+2 cycles
    for (int i = 0; i < 4; i++) run_op(rand_bcd(1'b0), rand_bcd(1'b0), 1'b1);
    start = 1'b0;
    @(negedge clk);

    // Reset during the second ADD cycle
    a = 16'h4321; b = 16'h5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_carry", carry, 0);
    check("abort_error", error, 0);
    check("abort_state", dbg_state, 0);
    for (int i = 0; i < DIGITS + 2; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    run_op(16'h0005, 16'h0005, 1'b0);

    // Randomized adds, some with invalid digits
    for (int i = 0; i < 30; i++) begin
      run_op(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        start = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    start = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
